// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: one outstanding sequential fetch, DEPTH-entry
// {inst, pc} buffer, redirect flush. Optional same-cycle bypass: PREFETCH_BYPASS_EN.
module inst_prefetch_queue #(
  parameter int             XLEN     = 32,
  parameter int             DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            req_valid_o,
  output logic [XLEN-1:0] req_addr_o,
  input  logic            req_ready_i,
  input  logic            rsp_valid_i,
  input  logic [XLEN-1:0] rsp_data_i,
  output logic            deq_valid_o,
  output logic [XLEN-1:0] deq_inst_o,
  output logic [XLEN-1:0] deq_pc_o,
  input  logic            deq_ready_i,
  output logic            empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t          state;
  logic            running;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] cap_pc;
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic rsp_live;
  logic bypass;
  logic do_enq;
  logic do_deq;
  logic req_fire;

  // running holds off the first request until one clock after reset release
  assign req_valid_o = running && (state == FETCH) && !redirect_i && (count < CW'(DEPTH));
  assign req_addr_o  = fetch_pc;
  assign req_fire    = req_valid_o && req_ready_i;
  assign rsp_live    = (state == WAIT) && rsp_valid_i && !redirect_i;

`ifdef PREFETCH_BYPASS_EN
  assign bypass = rsp_live && (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign deq_valid_o = ((count != '0) || bypass) && !redirect_i;
  assign deq_inst_o  = bypass ? rsp_data_i : inst_mem[rd_ptr];
  assign deq_pc_o    = bypass ? cap_pc : pc_mem[rd_ptr];
  assign do_deq      = (count != '0) && !redirect_i && deq_ready_i;
  assign do_enq      = rsp_live && !(bypass && deq_ready_i);
  assign empty_o     = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      running  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
      cap_pc   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      running <= 1'b1;
      if (redirect_i) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= redirect_pc_i & ~XLEN'(3);
        // a response landing with the redirect retires the outstanding request
        case (state)
          WAIT:    state <= rsp_valid_i ? FETCH : DROP;
          DROP:    state <= rsp_valid_i ? FETCH : DROP;
          default: state <= FETCH;
        endcase
      end else begin
        if (do_enq) begin
          inst_mem[wr_ptr] <= rsp_data_i;
          pc_mem[wr_ptr]   <= cap_pc;
          wr_ptr           <= wr_ptr + 1'b1;
        end
        if (do_deq) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(do_enq) - CW'(do_deq);
        case (state)
          FETCH: if (req_fire) begin
            cap_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= WAIT;
          end
          WAIT:    if (rsp_valid_i) state <= FETCH;
          DROP:    if (rsp_valid_i) state <= FETCH;
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Self-checking bench for inst_prefetch_queue: directed vector table, hand
// sequences for redirect/reset/bypass corners, and random traffic vs a queue model.
module tb_inst_prefetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic        deq_valid_o;
  logic [31:0] deq_inst_o;
  logic [31:0] deq_pc_o;
  logic        deq_ready_i;
  logic        empty_o;

  inst_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .deq_valid_o(deq_valid_o), .deq_inst_o(deq_inst_o), .deq_pc_o(deq_pc_o),
    .deq_ready_i(deq_ready_i), .empty_o(empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: queue of fetched entries plus the single outstanding request.
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_cap;
  int          m_out;       // 0 none, 1 live, 2 to be dropped
  bit          m_started;

  task automatic model_reset();
    mq.delete();
    m_pc      = RESET_PC;
    m_cap     = '0;
    m_out     = 0;
    m_started = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_i = 0; redirect_pc_i = '0; req_ready_i = 0;
    rsp_valid_i = 0; rsp_data_i = '0; deq_ready_i = 0;
    #1;
    chk("rst_empty", 32'(empty_o), 1);
    chk("rst_deq_valid", 32'(deq_valid_o), 0);
    chk("rst_req_valid", 32'(req_valid_o), 0);
    chk("rst_deq_inst", deq_inst_o, 0);
    chk("rst_deq_pc", deq_pc_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive at the falling edge, compare with the model, advance it.
  task automatic step(input bit rd, input logic [31:0] rpc, input bit rqr,
                      input bit rv, input logic [31:0] rdat, input bit dr);
    int   n;
    bit   byp, e_req, e_deq;
    ent_t h;
    @(negedge clk);
    redirect_i = rd; redirect_pc_i = rpc; req_ready_i = rqr;
    rsp_valid_i = rv; rsp_data_i = rdat; deq_ready_i = dr;
    #1;
    n   = mq.size();
    byp = 0;
`ifdef PREFETCH_BYPASS_EN
    byp = (n == 0) && (m_out == 1) && rv && !rd;
`endif
    e_req = m_started && (m_out == 0) && !rd && (n < DEPTH);
    e_deq = ((n != 0) || byp) && !rd;
    if (byp) begin h.inst = rdat; h.pc = m_cap; end
    else if (n != 0) h = mq[0];
    chk("m_req_valid", 32'(req_valid_o), 32'(e_req));
    if (e_req) chk("m_req_addr", req_addr_o, m_pc);
    chk("m_deq_valid", 32'(deq_valid_o), 32'(e_deq));
    if (e_deq) begin
      chk("m_deq_inst", deq_inst_o, h.inst);
      chk("m_deq_pc", deq_pc_o, h.pc);
    end
    chk("m_empty", 32'(empty_o), 32'(n == 0));
    if (rd) begin
      mq.delete();
      m_pc = rpc & ~32'h3;
      if (m_out != 0) m_out = rv ? 0 : 2;
    end else begin
      if (n != 0 && dr) void'(mq.pop_front());
      if (m_out == 1 && rv && !(byp && dr)) begin
        h.inst = rdat; h.pc = m_cap;
        mq.push_back(h);
      end
      if (m_out != 0 && rv) m_out = 0;
      else if (e_req && rqr) begin
        m_out = 1; m_cap = m_pc; m_pc = m_pc + 32'd4;
      end
    end
    m_started = 1;
  endtask

  // Always-ready memory answering one cycle after acceptance.
  task automatic run_mem(input int cycles, input bit dr);
    for (int i = 0; i < cycles; i++)
      step(0, '0, 1, m_out == 1, $urandom, dr);
  endtask

  typedef struct {
    bit rd; logic [31:0] rpc; bit rqr; bit rv; bit dr;
    bit e_req; logic [31:0] e_addr; bit e_deq; logic [31:0] e_pc; bit e_empty;
  } vec_t;
  vec_t tv[10];

  initial begin
    int          acc;
    logic [31:0] last_addr;

    //        rd rpc      rqr rv dr  req addr    deq pc     empty
    tv[0] = '{0, 32'h0,   1,  0, 1,  0, 32'h0,   0, 32'h0,  1};
    tv[1] = '{0, 32'h0,   1,  0, 1,  1, 32'h0,   0, 32'h0,  1};
    tv[2] = '{0, 32'h0,   1,  1, 1,  0, 32'h0,   0, 32'h0,  1};
    tv[3] = '{0, 32'h0,   1,  0, 1,  1, 32'h4,   1, 32'h0,  0};
    tv[4] = '{0, 32'h0,   1,  1, 1,  0, 32'h0,   0, 32'h0,  1};
    tv[5] = '{0, 32'h0,   1,  0, 1,  1, 32'h8,   1, 32'h4,  0};
    tv[6] = '{0, 32'h0,   1,  1, 1,  0, 32'h0,   0, 32'h0,  1};
    tv[7] = '{0, 32'h0,   1,  0, 1,  1, 32'hC,   1, 32'h8,  0};
    tv[8] = '{1, 32'h42,  1,  1, 1,  0, 32'h0,   0, 32'h0,  1};
    tv[9] = '{0, 32'h0,   1,  0, 1,  1, 32'h40,  0, 32'h0,  1};

    model_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tv[i].rd, tv[i].rpc, tv[i].rqr, tv[i].rv, 32'h0000_0013, tv[i].dr);
      chk($sformatf("tv%0d_req_valid", i), 32'(req_valid_o), 32'(tv[i].e_req));
      if (tv[i].e_req) chk($sformatf("tv%0d_req_addr", i), req_addr_o, tv[i].e_addr);
      chk($sformatf("tv%0d_deq_valid", i), 32'(deq_valid_o), 32'(tv[i].e_deq));
      if (tv[i].e_deq) begin
        chk($sformatf("tv%0d_deq_pc", i), deq_pc_o, tv[i].e_pc);
        chk($sformatf("tv%0d_deq_inst", i), deq_inst_o, 32'h0000_0013);
      end
      chk($sformatf("tv%0d_empty", i), 32'(empty_o), 32'(tv[i].e_empty));
    end

    // Backpressure: queue fills with four entries, then fetch stops.
    do_reset();
    acc = 0; last_addr = '1;
    for (int i = 0; i < 16; i++) begin
      step(0, '0, 1, m_out == 1, $urandom, 0);
      if (req_valid_o) begin acc++; last_addr = req_addr_o; end
    end
    chk("bp_accepts", acc, 4);
    chk("bp_last_addr", last_addr, 32'hC);
    chk("bp_stalled", 32'(req_valid_o), 0);
    step(0, '0, 1, 0, '0, 1);
    step(0, '0, 1, 0, '0, 0);
    chk("bp_resume_valid", 32'(req_valid_o), 1);
    chk("bp_resume_addr", req_addr_o, 32'h10);

    // Redirect while a request is outstanding: its response is dropped.
    do_reset();
    run_mem(2, 1);
    step(1, 32'h100, 1, 0, '0, 1);
    chk("rw_req_blocked", 32'(req_valid_o), 0);
    step(0, '0, 1, 1, 32'hDEAD_BEEF, 1);
    chk("rw_empty_after", 32'(empty_o), 1);
    chk("rw_no_deq", 32'(deq_valid_o), 0);
    step(0, '0, 1, 0, '0, 1);
    chk("rw_req_valid", 32'(req_valid_o), 1);
    chk("rw_req_addr", req_addr_o, 32'h100);
    step(0, '0, 1, 1, 32'h55, 1);
    step(0, '0, 1, 0, '0, 1);
    chk("rw_deq_valid", 32'(deq_valid_o), 1);
    chk("rw_deq_pc", deq_pc_o, 32'h100);
    chk("rw_deq_inst", deq_inst_o, 32'h55);

    // Redirect with unaligned target, coincident response and dequeue, 2 queued.
    do_reset();
    run_mem(6, 0);
    chk("r2_not_empty", 32'(empty_o), 0);
    step(1, 32'h203, 1, 1, 32'h1234, 1);
    chk("r2_no_deq", 32'(deq_valid_o), 0);
    chk("r2_no_req", 32'(req_valid_o), 0);
    step(0, '0, 1, 0, '0, 1);
    chk("r2_empty", 32'(empty_o), 1);
    chk("r2_req_valid", 32'(req_valid_o), 1);
    chk("r2_req_addr", req_addr_o, 32'h200);

    // Response into an empty queue with decode ready.
    do_reset();
    run_mem(2, 1);
    step(0, '0, 1, 1, 32'hABCD, 1);
`ifdef PREFETCH_BYPASS_EN
    chk("byp_deq_valid", 32'(deq_valid_o), 1);
    chk("byp_deq_inst", deq_inst_o, 32'hABCD);
    chk("byp_deq_pc", deq_pc_o, 32'h0);
    step(0, '0, 0, 0, '0, 1);
    chk("byp_empty_after", 32'(empty_o), 1);
`else
    chk("nobyp_deq_valid", 32'(deq_valid_o), 0);
    step(0, '0, 0, 0, '0, 1);
    chk("nobyp_deq_late", 32'(deq_valid_o), 1);
    chk("nobyp_deq_inst", deq_inst_o, 32'hABCD);
`endif

    // Asynchronous reset mid-WAIT with three entries queued.
    do_reset();
    run_mem(8, 0);
    chk("ar_not_empty", 32'(empty_o), 0);
    #2;
    do_reset();
    step(0, '0, 1, 0, '0, 0);
    step(0, '0, 1, 0, '0, 0);
    chk("ar_first_req", 32'(req_valid_o), 1);
    chk("ar_first_addr", req_addr_o, RESET_PC);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit rd;
      rd = ($urandom_range(0, 11) == 0);
      step(rd, $urandom, $urandom_range(0, 3) != 0,
           (m_out != 0) && ($urandom_range(0, 2) != 0), $urandom, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
